maxnet_winner_select: RTL and testbench

Winner-selection back end for the 4-lane MaxNet datapath. Each cycle it classifies the four 32-bit IEEE 754 activation words as zero or non-zero, raises `done` when exactly one lane survives, encodes the surviving lane to a 2-bit index, and returns the stored initial input value of that lane as `max`. It sits after the activation registers and feeds the controller (`done`) and the top-level result port (`max`). Internally it contains a zero detector per lane, a 4-to-2 encoder and a 4:1 32-bit multiplexer; all outputs are registered.

---
 rtl/maxnet_winner_select.sv | 117 +++++++++++
 tb/tb_maxnet_winner_select.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/maxnet_winner_select.sv
// -----------------------------------------------------------------------------
// maxnet_winner_select
//
// Winner-selection back end for the 4-lane MaxNet datapath. Every cycle it
// classifies the four activation words as zero / non-zero. It flags `done`
// when exactly one lane survives. It encodes the surviving lane to a 2-bit
// index and returns that lane's initial input value on `max`. All outputs
// are registered with one cycle of latency. There is no enable and no hold,
// so the outputs keep tracking the inputs.
//
// Build option:
//   MAXNET_NEG_ZERO_EN  defined   : -0 (32'h80000000) counts as zero
//                                   (the sign bit is ignored).
//                       undefined : only 32'h00000000 counts as zero, so
//                                   -0 is a surviving lane.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   a1..a4     in  32   current activations (IEEE 754 single), lane 1 = a1
//   x1..x4     in  32   initial input values of lanes 1..4
//   zero       out  4   registered zero flags {z1,z2,z3,z4} (bit 3 = lane 1)
//   sig        out  2   registered winner index (0..3 = lanes 1..4)
//   done       out  1   registered, 1 when exactly three lanes are zero
//   max        out 32   registered x value of the lane selected by sig
// -----------------------------------------------------------------------------
module maxnet_winner_select (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a1,
   input  logic [31:0] a2,
   input  logic [31:0] a3,
   input  logic [31:0] a4,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   input  logic [31:0] x3,
   input  logic [31:0] x4,
   output logic [3:0]  zero,
   output logic [1:0]  sig,
   output logic        done,
   output logic [31:0] max
);

   // Bits that take part in the zero comparison. Masking the sign bit makes
   // +0 and -0 compare equal.
`ifdef MAXNET_NEG_ZERO_EN
   localparam logic [31:0] ZERO_MASK = 32'h7FFF_FFFF;
`else
   localparam logic [31:0] ZERO_MASK = 32'hFFFF_FFFF;
`endif

   logic [3:0]  zero_d, zero_q;
   logic [1:0]  sig_d,  sig_q;
   logic        done_d, done_q;
   logic [31:0] max_d,  max_q;
   logic [2:0]  zero_cnt;

   always_comb begin
      // NOTE: every signal gets a default at the top of the block, so no
      // path can leave it unassigned and infer a latch.
      zero_d   = 4'b0000;
      zero_cnt = 3'd0;
      sig_d    = 2'd0;
      done_d   = 1'b0;
      max_d    = 32'h0;

      zero_d[3] = ((a1 & ZERO_MASK) == 32'h0);
      zero_d[2] = ((a2 & ZERO_MASK) == 32'h0);
      zero_d[1] = ((a3 & ZERO_MASK) == 32'h0);
      zero_d[0] = ((a4 & ZERO_MASK) == 32'h0);

      zero_cnt = {2'b00, zero_d[3]} + {2'b00, zero_d[2]}
               + {2'b00, zero_d[1]} + {2'b00, zero_d[0]};
      done_d   = (zero_cnt == 3'd3);

      // Lowest-numbered non-zero lane wins. This covers the single-survivor
      // patterns and the multi-survivor patterns alike. All-zero falls
      // through to lane 1.
      if (!zero_d[3])      sig_d = 2'd0;
      else if (!zero_d[2]) sig_d = 2'd1;
      else if (!zero_d[1]) sig_d = 2'd2;
      else if (!zero_d[0]) sig_d = 2'd3;
      else                 sig_d = 2'd0;

      unique case (sig_d)
         2'd0: max_d = x1;
         2'd1: max_d = x2;
         2'd2: max_d = x3;
         2'd3: max_d = x4;
         default: max_d = x1;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments. All flops then
      // sample the pre-edge values, with no dependence on statement order.
      if (rst) begin
         // NOTE: only these few output flops exist. All of them are cleared
         // on reset, so nothing downstream ever sees stale data.
         zero_q <= 4'b0000;
         sig_q  <= 2'd0;
         done_q <= 1'b0;
         max_q  <= 32'h0;
      end else begin
         zero_q <= zero_d;
         sig_q  <= sig_d;
         done_q <= done_d;
         max_q  <= max_d;
      end
   end

   assign zero = zero_q;
   assign sig  = sig_q;
   assign done = done_q;
   assign max  = max_q;

endmodule

// File: tb/tb_maxnet_winner_select.sv
// -----------------------------------------------------------------------------
// tb_maxnet_winner_select
//
// Self-checking bench for maxnet_winner_select. A behavioural model computes
// the expected outputs from the lane values with plain loops over arrays. The
// model follows the same build option (MAXNET_NEG_ZERO_EN) as the design.
// -----------------------------------------------------------------------------
module tb_maxnet_winner_select;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a [4];
   logic [31:0] x [4];
   logic [3:0]  zero;
   logic [1:0]  sig;
   logic        done;
   logic [31:0] max;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   maxnet_winner_select dut (
      .clk  (clk),
      .rst  (rst),
      .a1   (a[0]),
      .a2   (a[1]),
      .a3   (a[2]),
      .a4   (a[3]),
      .x1   (x[0]),
      .x2   (x[1]),
      .x3   (x[2]),
      .x4   (x[3]),
      .zero (zero),
      .sig  (sig),
      .done (done),
      .max  (max)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_zero(input logic [31:0] v);
`ifdef MAXNET_NEG_ZERO_EN
      return (v == 32'h0) || (v == 32'h8000_0000);
`else
      return (v == 32'h0);
`endif
   endfunction

   // Applies one clock edge with the current inputs and rst = r. The outputs
   // are checked 1 time unit after the edge. The task returns on the next
   // falling edge, so the caller can set up the following cycle.
   task automatic run_cycle(input bit r, input string tag);
      logic [3:0]  e_zero;
      logic [1:0]  e_sig;
      logic        e_done;
      logic [31:0] e_max;
      int          cnt;
      int          win;
      cnt    = 0;
      win    = -1;
      e_zero = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (is_zero(a[i])) begin
            cnt++;
            e_zero[3-i] = 1'b1;
         end else if (win < 0) begin
            win = i;
         end
      end
      if (win < 0) win = 0;
      e_sig  = 2'(win);
      e_done = (cnt == 3);
      e_max  = x[win];
      if (r) begin
         e_zero = 4'b0000;
         e_sig  = 2'd0;
         e_done = 1'b0;
         e_max  = 32'h0;
      end
      rst = r;
      @(posedge clk);
      #1;
      check({tag, ".zero"}, {28'h0, zero}, {28'h0, e_zero});
      check({tag, ".sig"},  {30'h0, sig},  {30'h0, e_sig});
      check({tag, ".done"}, {31'h0, done}, {31'h0, e_done});
      check({tag, ".max"},  max,           e_max);
      @(negedge clk);
   endtask

   task automatic set_a(input logic [31:0] v0, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] v3);
      a[0] = v0; a[1] = v1; a[2] = v2; a[3] = v3;
   endtask

   function automatic logic [31:0] rand_lane();
      case ($urandom_range(0, 4))
         0, 1:    return 32'h0;
         2:       return 32'h8000_0000;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a[i] = $urandom();
         x[i] = $urandom();
      end
      @(negedge clk);

      // Reset with arbitrary, non-zero-looking inputs.
      set_a(32'h3F80_0000, 32'h0, 32'h0, 32'h0);
      run_cycle(1'b1, "reset");
      check("reset_max_const", max, 32'h0);

      // x = {1.0, 2.0, 3.0, 4.0}
      x[0] = 32'h3F80_0000; x[1] = 32'h4000_0000;
      x[2] = 32'h4040_0000; x[3] = 32'h4080_0000;

      // Single survivor in lane 3.
      set_a(32'h0, 32'h0, 32'h3F80_0000, 32'h0);
      run_cycle(1'b0, "lane3");
      check("lane3_zero_const", {28'h0, zero}, 32'hD);
      check("lane3_sig_const",  {30'h0, sig},  32'd2);
      check("lane3_done_const", {31'h0, done}, 32'd1);
      check("lane3_max_const",  max,           32'h4040_0000);

      set_a(32'h3F80_0000, 32'h0, 32'h0, 32'h0);
      run_cycle(1'b0, "lane1");
      set_a(32'h0, 32'h3F80_0000, 32'h0, 32'h0);
      run_cycle(1'b0, "lane2");
      set_a(32'h0, 32'h0, 32'h0, 32'hBF80_0000);
      run_cycle(1'b0, "lane4");
      check("lane4_sig_const", {30'h0, sig}, 32'd3);
      check("lane4_max_const", max, 32'h4080_0000);

      // Multiple survivors: the lowest non-zero lane wins, done stays low.
      set_a(32'h0, 32'h3F00_0000, 32'h3E80_0000, 32'h0);
      run_cycle(1'b0, "multi");
      check("multi_sig_const", {30'h0, sig}, 32'd1);
      check("multi_done_const", {31'h0, done}, 32'd0);

      // All zero.
      set_a(32'h0, 32'h0, 32'h0, 32'h0);
      run_cycle(1'b0, "allzero");
      check("allzero_sig_const", {30'h0, sig}, 32'd0);

      // A denormal, a NaN and an infinity are all non-zero.
      set_a(32'h0, 32'h0000_0001, 32'h0, 32'h0);
      run_cycle(1'b0, "denorm");
      set_a(32'h7FC0_0000, 32'h0, 32'h0, 32'h0);
      run_cycle(1'b0, "nan");
      set_a(32'h0, 32'h0, 32'hFF80_0000, 32'h0);
      run_cycle(1'b0, "inf");

      // Negative zero in lane 1.
      set_a(32'h8000_0000, 32'h0, 32'h0, 32'h3F80_0000);
      run_cycle(1'b0, "negzero");
`ifdef MAXNET_NEG_ZERO_EN
      check("negzero_sig_const", {30'h0, sig}, 32'd3);
      check("negzero_done_const", {31'h0, done}, 32'd1);
`else
      check("negzero_zero_const", {28'h0, zero}, 32'h6);
      check("negzero_sig_const", {30'h0, sig}, 32'd0);
      check("negzero_done_const", {31'h0, done}, 32'd0);
`endif

      // Random stream with new inputs every cycle and a one-cycle reset in
      // the middle.
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 4; i++) begin
            a[i] = rand_lane();
            x[i] = $urandom();
         end
         run_cycle(n == 150, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: got no_finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
